// File: rtl/seg7_pkg.sv
// Shared types and the 7-segment hex font for the scan driver.
// Patterns are {G,F,E,D,C,B,A}, active-low (0 = segment lit).
package seg7_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_FONT[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with a blanking override.
// Output is always active-low; polarity is applied by the caller.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Font lookup unless the digit is blanked
    always_comb begin
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            o_seg = hex_to_seg(i_nibble);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver: slot/phase/digit counters, per-frame
// input snapshot, leading-zero blanking, PWM brightness and registered pins.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SLOT_CYCLES    = 100_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int SUB_MAX = SLOT_CYCLES / 16;
    localparam int SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

    scan_state_t             r_state, w_state_nxt;
    logic [SUB_W-1:0]        r_sub_cnt, w_sub_nxt;
    logic [3:0]              r_phase, w_phase_nxt;
    logic [DIG_W-1:0]        r_digit, w_digit_nxt;
    logic                    w_snap, w_wrap, w_sub_last, w_dig_last;

    logic [4*NUM_DIGITS-1:0] r_data_sh;
    logic [NUM_DIGITS-1:0]   r_dp_sh, r_den_sh;
    logic [3:0]              r_bright_sh;
    logic                    r_lz_sh;

    logic                    w_active, w_zero_run, w_lz_blank, w_dp_bit, w_lit, w_dp_lit;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_an_hot;
    logic [6:0]              w_seg_pat;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp_out, r_frame_done;

    assign w_sub_last = (r_sub_cnt == SUB_W'(SUB_MAX - 1));
    assign w_dig_last = (r_digit == DIG_W'(NUM_DIGITS - 1));

    // FSM and counter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sub_cnt <= '0;
            r_phase   <= 4'd0;
            r_digit   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sub_cnt <= w_sub_nxt;
            r_phase   <= w_phase_nxt;
            r_digit   <= w_digit_nxt;
        end
    end

    // Next-state and counter advance; leaving SCAN or sitting in IDLE clears all counters
    always_comb begin
        w_state_nxt = r_state;
        w_sub_nxt   = '0;
        w_phase_nxt = 4'd0;
        w_digit_nxt = '0;
        w_snap      = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_SCAN;
                    w_snap      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SCAN;
                    w_phase_nxt = r_phase;
                    w_digit_nxt = r_digit;
                    if (!w_sub_last) begin
                        w_sub_nxt = r_sub_cnt + SUB_W'(1);
                    end else if (r_phase != 4'd15) begin
                        w_phase_nxt = r_phase + 4'd1;
                    end else if (!w_dig_last) begin
                        w_phase_nxt = 4'd0;
                        w_digit_nxt = r_digit + DIG_W'(1);
                    end else begin
                        w_phase_nxt = 4'd0;
                        w_digit_nxt = '0;
                        w_wrap      = 1'b1;
                        w_snap      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shadow copy of the display inputs, refreshed only at frame boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_sh   <= '0;
            r_dp_sh     <= '0;
            r_den_sh    <= '0;
            r_bright_sh <= 4'd0;
            r_lz_sh     <= 1'b0;
        end else if (w_snap) begin
            r_data_sh   <= data;
            r_dp_sh     <= dp;
            r_den_sh    <= digit_en;
            r_bright_sh <= brightness;
            r_lz_sh     <= lz_suppress;
        end else begin
            r_data_sh   <= r_data_sh;
            r_dp_sh     <= r_dp_sh;
            r_den_sh    <= r_den_sh;
            r_bright_sh <= r_bright_sh;
            r_lz_sh     <= r_lz_sh;
        end
    end

    // Phase 15 is a guard interval so adjacent digits never ghost
    assign w_active = (r_state == ST_SCAN) && en && (r_phase < r_bright_sh) && (r_phase != 4'd15);

    // Select the current digit's fields; w_zero_run tracks "all digits so far are zero"
    always_comb begin
        w_nib      = 4'd0;
        w_dp_bit   = 1'b0;
        w_lz_blank = 1'b0;
        w_zero_run = 1'b1;
        w_an_hot   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero_run = w_zero_run & (r_data_sh[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            w_nib      = w_nib | ((DIG_W'(i) == r_digit) ? r_data_sh[4*(NUM_DIGITS-1-i) +: 4] : 4'd0);
            w_dp_bit   = w_dp_bit | ((DIG_W'(i) == r_digit) & r_dp_sh[NUM_DIGITS-1-i]);
            w_lz_blank = w_lz_blank | ((DIG_W'(i) == r_digit) & r_lz_sh & w_zero_run
                                       & (i != NUM_DIGITS - 1));
            w_an_hot[NUM_DIGITS-1-i] = (DIG_W'(i) == r_digit) & r_den_sh[NUM_DIGITS-1-i] & w_active;
        end
    end

    assign w_lit    = |w_an_hot;
    assign w_dp_lit = w_lit & w_dp_bit;

    seg7_decode u_decode (
        .i_nibble (w_nib),
        .i_blank  (~w_lit | w_lz_blank),
        .o_seg    (w_seg_pat)
    );

    // Output pin registers with board polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp_out     <= DP_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= AN_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
            r_seg        <= SEG_ACTIVE_LOW ? w_seg_pat : ~w_seg_pat;
            r_dp_out     <= SEG_ACTIVE_LOW ? ~w_dp_lit : w_dp_lit;
            r_frame_done <= w_wrap;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp_out     = r_dp_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (8 digits, 32-cycle slots, active-low pins).
// A time-indexed reference model predicts every output each cycle; directed checks cover key cases.
module tb_seg7_scan_ctrl;

    localparam int ND    = 8;
    localparam int SLOT  = 32;
    localparam int FRAME = ND * SLOT;

    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk = 1'b0;
    logic          rst_n, en, lz_suppress;
    logic [31:0]   data;
    logic [7:0]    dp, digit_en, an;
    logic [3:0]    brightness;
    logic [6:0]    seg;
    logic          dp_out, frame_done;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .SLOT_CYCLES    (SLOT),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .data        (data),
        .dp          (dp),
        .digit_en    (digit_en),
        .brightness  (brightness),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp_out      (dp_out),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic lz_blank(input logic [31:0] d, input logic lz, input int dig);
        if (!lz || dig == ND - 1) return 1'b0;
        for (int j = 0; j <= dig; j++) begin
            if (((d >> (4 * (ND - 1 - j))) & 32'hF) != 32'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: m_k counts cycles since scanning began; digit/phase follow by division
    initial begin : model
        bit          m_scan;
        int          m_k, dig, ph;
        logic [31:0] m_data;
        logic [7:0]  m_dp, m_den, e_an;
        logic [3:0]  m_bri, nib;
        logic [6:0]  e_seg;
        logic        m_lz, lit, e_dp, e_fd;
        m_scan = 1'b0; m_k = 0; m_data = 32'h0; m_dp = 8'h0; m_den = 8'h0; m_bri = 4'h0; m_lz = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_scan = 1'b0; m_k = 0;
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            end else begin
                dig   = (m_k / SLOT) % ND;
                ph    = (m_k % SLOT) / (SLOT / 16);
                lit   = m_scan && en && m_den[ND-1-dig] && (ph < int'(m_bri)) && (ph != 15);
                nib   = 4'((m_data >> (4 * (ND - 1 - dig))) & 32'hF);
                e_an  = lit ? ~(8'h80 >> dig) : 8'hFF;
                e_seg = (!lit || lz_blank(m_data, m_lz, dig)) ? 7'h7F : FONT[nib];
                e_dp  = !(lit && m_dp[ND-1-dig]);
                e_fd  = m_scan && en && ((m_k % FRAME) == FRAME - 1);
                if (!m_scan) begin
                    if (en) begin
                        m_scan = 1'b1; m_k = 0;
                        m_data = data; m_dp = dp; m_den = digit_en; m_bri = brightness; m_lz = lz_suppress;
                    end
                end else if (!en) begin
                    m_scan = 1'b0;
                end else begin
                    m_k++;
                    if ((m_k % FRAME) == 0) begin
                        m_data = data; m_dp = dp; m_den = digit_en; m_bri = brightness; m_lz = lz_suppress;
                    end
                end
            end
            #1;
            check_val("model_an", {24'h0, an}, {24'h0, e_an});
            check_val("model_seg", {25'h0, seg}, {25'h0, e_seg});
            check_val("model_dp", {31'h0, dp_out}, {31'h0, e_dp});
            check_val("model_frame_done", {31'h0, frame_done}, {31'h0, e_fd});
        end
    end

    task automatic restart(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m,
                           input logic [3:0] b, input logic z);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        data = d; dp = p; digit_en = m; brightness = b; lz_suppress = z;
        en = 1'b1;
    endtask

    initial begin : stim
        int cnt_a, cnt_f, n_cyc;
        rst_n = 1'b0; en = 1'b0; data = 32'h0; dp = 8'h0; digit_en = 8'hFF;
        brightness = 4'd0; lz_suppress = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic scan order and font
        restart(32'h0123ABCD, 8'h00, 8'hFF, 4'd15, 1'b0);
        repeat (2) @(posedge clk); #1;
        check_val("scan_an_d0", {24'h0, an}, 32'h7F);
        check_val("scan_seg_d0", {25'h0, seg}, {25'h0, 7'b1000000});
        repeat (128) @(posedge clk); #1;
        check_val("scan_an_d4", {24'h0, an}, 32'hF7);
        check_val("scan_seg_d4", {25'h0, seg}, {25'h0, 7'b0001000});
        cnt_f = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            if (frame_done) cnt_f++;
        end
        check_val("scan_frame_pulses", cnt_f, 32'd1);

        // Leading-zero suppression
        restart(32'h00000050, 8'h00, 8'hFF, 4'd15, 1'b1);
        repeat (2) @(posedge clk); #1;
        check_val("lz_an_d0", {24'h0, an}, 32'h7F);
        check_val("lz_seg_d0", {25'h0, seg}, 32'h7F);
        repeat (192) @(posedge clk); #1;
        check_val("lz_seg_d6", {25'h0, seg}, {25'h0, 7'b0010010});
        repeat (32) @(posedge clk); #1;
        check_val("lz_seg_d7", {25'h0, seg}, {25'h0, 7'b1000000});
        restart(32'h00000000, 8'h00, 8'hFF, 4'd15, 1'b1);
        cnt_a = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            if (seg != 7'h7F) cnt_a++;
        end
        check_val("lz_zero_lit_cycles", cnt_a, 32'd30);

        // Brightness 4 and 0
        restart(32'h89ABCDEF, 8'h00, 8'hFF, 4'd4, 1'b0);
        cnt_a = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk); #1;
            if (an == 8'h7F) cnt_a++;
        end
        check_val("bright4_on_cycles", cnt_a, 32'd8);
        restart(32'h89ABCDEF, 8'hFF, 8'hFF, 4'd0, 1'b0);
        cnt_a = 0; cnt_f = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (an != 8'hFF) cnt_a++;
            if (frame_done) cnt_f++;
        end
        check_val("bright0_an_active", cnt_a, 32'd0);
        check_val("bright0_frame_pulses", cnt_f, 32'd1);

        // Mid-frame data change is not displayed
        restart(32'h11111111, 8'h00, 8'hFF, 4'd15, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        data = 32'h22222222;
        @(posedge clk); #1;
        check_val("midframe_seg_held", {25'h0, seg}, {25'h0, 7'b1111001});
        repeat (200) @(posedge clk);

        // en drop mid-slot, then restart with digit 3 masked
        restart(32'h0123ABCD, 8'hA5, 8'hFF, 4'd15, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check_val("en_off_an", {24'h0, an}, 32'hFF);
        check_val("en_off_seg", {25'h0, seg}, 32'h7F);
        @(negedge clk);
        digit_en = 8'hEF; en = 1'b1;
        cnt_a = 0; cnt_f = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (an == 8'hEF) cnt_a++;
            if (frame_done) cnt_f++;
        end
        check_val("mask_d3_active", cnt_a, 32'd0);
        check_val("mask_frame_pulses", cnt_f, 32'd1);

        // Randomized traffic against the model
        for (int r = 0; r < 8; r++) begin
            restart($urandom >> (4 * $urandom_range(0, 8)), 8'($urandom), 8'($urandom),
                    4'($urandom), 1'($urandom));
            n_cyc = $urandom_range(100, 700);
            for (int c = 0; c < n_cyc; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 36) == 0) begin
                    data = $urandom >> (4 * $urandom_range(0, 8));
                    dp = 8'($urandom); digit_en = 8'($urandom);
                    brightness = 4'($urandom); lz_suppress = 1'($urandom);
                end
                en = ($urandom_range(0, 199) != 0);
            end
        end

        // Asynchronous reset mid-frame
        restart(32'hFEDCBA98, 8'hFF, 8'hFF, 4'd15, 1'b0);
        repeat (255) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_rst_an", {24'h0, an}, 32'hFF);
        check_val("async_rst_seg", {25'h0, seg}, 32'h7F);
        check_val("async_rst_dp", {31'h0, dp_out}, 32'd1);
        check_val("async_rst_frame_done", {31'h0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);

        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
